mem_test_ctrl: RTL and testbench

Memory self-test sequencer sitting directly upstream of the `comparator` stage and consuming its `is_equal` result. It runs a four-phase write/read-back pattern test over a synchronous single-port memory and presents the expected word on `data_gen`, aligned with the memory read data that feeds the comparator's `data_mem` input. It then accumulates the comparator verdicts into an error count, a first-failing address, and a pass/done status.

---
 rtl/mem_test_ctrl.sv | 130 +++++++++++++
 tb/tb_mem_test_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_test_ctrl.sv
// Memory self-test sequencer: four-phase write/read-back pattern test with a
// one-cycle compare pipeline feeding the downstream comparator.
module mem_test_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     mem_we,
  output logic                     mem_re,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic [DATA_WIDTH-1:0]    data_gen,
  input  logic                     is_equal,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic [ADDR_WIDTH-1:0]    first_err_addr,
  output logic                     first_err_valid
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR0, S_RD0, S_WR1, S_RD1, S_CHK, S_DONE
  } state_t;

  localparam logic [DATA_WIDTH-1:0] PAT_BASE = {(DATA_WIDTH/2){2'b10}};

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a,
                                                    input logic inv);
    logic [DATA_WIDTH-1:0] p;
    p = PAT_BASE ^ DATA_WIDTH'(a);
    return inv ? ~p : p;
  endfunction

  function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] c);
    return (&c) ? c : c + ERR_CNT_WIDTH'(1);
  endfunction

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    addr_last;
  logic                    start_ok;
  logic [DATA_WIDTH-1:0]   rd_exp_p0;
  logic                    vld_p1;
  logic [ADDR_WIDTH-1:0]   cmp_addr_p1;
  logic [DATA_WIDTH-1:0]   exp_p1;
  logic                    mismatch;

  assign addr_last = &addr;
  assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE));
  assign mem_addr  = addr;
  assign data_gen  = exp_p1;
  assign mismatch  = vld_p1 && !is_equal;
  assign pass      = done && (err_count == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_WR0;
      S_WR0:          if (addr_last) state_nxt = S_RD0;
      S_RD0:          if (addr_last) state_nxt = S_WR1;
      S_WR1:          if (addr_last) state_nxt = S_RD1;
      S_RD1:          if (addr_last) state_nxt = S_CHK;
      S_CHK:          state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_wdata = '0;
    rd_exp_p0 = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_WR0: begin mem_we = 1'b1; mem_wdata = pattern(addr, 1'b0); busy = 1'b1; end
      S_RD0: begin mem_re = 1'b1; rd_exp_p0 = pattern(addr, 1'b0); busy = 1'b1; end
      S_WR1: begin mem_we = 1'b1; mem_wdata = pattern(addr, 1'b1); busy = 1'b1; end
      S_RD1: begin mem_re = 1'b1; rd_exp_p0 = pattern(addr, 1'b1); busy = 1'b1; end
      S_CHK:  busy = 1'b1;
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Address sweep: wraps to 0 naturally as each phase ends at D-1
  always_ff @(posedge clk) begin
    if (rst || start_ok)
      addr <= '0;
    else if ((state == S_WR0) || (state == S_RD0) || (state == S_WR1) || (state == S_RD1))
      addr <= addr + ADDR_WIDTH'(1);
  end

  // p0 -> p1: read cycle registers its expected word alongside the memory latency
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      exp_p1 <= '0;
    end else begin
      vld_p1 <= mem_re;
      if (mem_re) exp_p1 <= rd_exp_p0;
    end
    if (mem_re) cmp_addr_p1 <= addr;
  end

  // p1: comparator verdict accumulates on the edge that ends the compare cycle
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      err_count       <= '0;
      first_err_addr  <= '0;
      first_err_valid <= 1'b0;
    end else if (mismatch) begin
      err_count <= sat_inc(err_count);
      if (!first_err_valid) begin
        first_err_addr  <= cmp_addr_p1;
        first_err_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_test_ctrl.sv
// Bench for mem_test_ctrl: two instances (8-bit and 4-bit error counters) on
// faulty memory models, checked every cycle against a cycle-index model.
module tb_mem_test_ctrl;
  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int D   = 1 << AW;
  localparam int EWA = 8;
  localparam int EWB = 4;
  localparam int DONE_LAT = 4 * D + 1;

  logic clk = 1'b0;
  logic rst, start;
  always #5 clk = ~clk;

  logic           we_a, re_a, eq_a, busy_a, done_a, pass_a, fev_a;
  logic [AW-1:0]  addr_a, fea_a;
  logic [DW-1:0]  wdata_a, gen_a, rdata_a;
  logic [EWA-1:0] err_a;
  logic           we_b, re_b, eq_b, busy_b, done_b, pass_b, fev_b;
  logic [AW-1:0]  addr_b, fea_b;
  logic [DW-1:0]  wdata_b, gen_b, rdata_b;
  logic [EWB-1:0] err_b;

  mem_test_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ERR_CNT_WIDTH(EWA)) dut_a (
    .clk(clk), .rst(rst), .start(start), .mem_we(we_a), .mem_re(re_a),
    .mem_addr(addr_a), .mem_wdata(wdata_a), .data_gen(gen_a), .is_equal(eq_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .first_err_addr(fea_a), .first_err_valid(fev_a));

  mem_test_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ERR_CNT_WIDTH(EWB)) dut_b (
    .clk(clk), .rst(rst), .start(start), .mem_we(we_b), .mem_re(re_b),
    .mem_addr(addr_b), .mem_wdata(wdata_b), .data_gen(gen_b), .is_equal(eq_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_err_addr(fea_b), .first_err_valid(fev_b));

  // Fault modes: 0 ideal, 1 bit0 stuck-at-0 at addr 3, 2 always reads 0, 3 random xor
  int            mode = 0;
  logic [DW-1:0] xmask [D];

  function automatic logic [DW-1:0] fault(input int a, input logic [DW-1:0] w);
    case (mode)
      1:       return (a == 3) ? (w & 8'hFE) : w;
      2:       return '0;
      3:       return w ^ xmask[a];
      default: return w;
    endcase
  endfunction

  function automatic logic [DW-1:0] pat(input int a, input bit inv);
    logic [DW-1:0] p;
    p = 8'hAA ^ DW'(a);
    return inv ? ~p : p;
  endfunction

  function automatic int sat(input int c, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (c > mx) ? mx : c;
  endfunction

  logic [DW-1:0] mem_a [D];
  logic [DW-1:0] mem_b [D];
  initial begin
    for (int i = 0; i < D; i++) begin mem_a[i] = '0; mem_b[i] = '0; xmask[i] = '0; end
    rdata_a = '0;
    rdata_b = '0;
  end

  always @(posedge clk) begin
    if (we_a) mem_a[addr_a] <= wdata_a;
    if (re_a) rdata_a <= fault(int'(addr_a), mem_a[addr_a]);
    if (we_b) mem_b[addr_b] <= wdata_b;
    if (re_b) rdata_b <= fault(int'(addr_b), mem_b[addr_b]);
  end
  assign eq_a = (gen_a == rdata_a);
  assign eq_b = (gen_b == rdata_b);

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: test progress is a cycle index k since the start edge
  bit            m_active = 0, m_done = 0, m_fev = 0;
  int            m_k = 0, m_cnt = 0, m_fea = 0;
  logic [DW-1:0] m_gen = '0;
  logic [DW-1:0] mmem [D];
  bit            pend_v = 0, pend_mis = 0;
  int            pend_a = 0;
  initial for (int i = 0; i < D; i++) mmem[i] = '0;

  always @(posedge clk) begin : model
    int ph, a;
    logic [DW-1:0] w;
    if (rst) begin
      m_active = 0; m_done = 0; m_cnt = 0; m_fev = 0; m_fea = 0;
      m_gen = '0; pend_v = 0; m_k = 0;
    end else if (!m_active && start) begin
      m_active = 1; m_k = 0; m_done = 0; m_cnt = 0; m_fev = 0; m_fea = 0; pend_v = 0;
    end else if (m_active) begin
      if (pend_v && pend_mis) begin
        m_cnt++;
        if (!m_fev) begin m_fev = 1; m_fea = pend_a; end
      end
      pend_v = 0;
      if (m_k < 4 * D) begin
        ph = m_k / D;
        a  = m_k % D;
        w  = pat(a, ph >= 2);
        if (ph % 2 == 0) mmem[a] = w;
        else begin
          pend_v = 1; pend_a = a; m_gen = w;
          pend_mis = (fault(a, mmem[a]) != w);
        end
      end
      m_k++;
      if (m_k == DONE_LAT) begin m_active = 0; m_done = 1; end
    end
  end

  always @(negedge clk) begin : compare
    int ph, a;
    bit e_we, e_re;
    if (chk_en) begin
      e_we = 0; e_re = 0; ph = 0; a = 0;
      if (m_active && m_k < 4 * D) begin
        ph = m_k / D;
        a  = m_k % D;
        e_we = (ph % 2 == 0);
        e_re = (ph % 2 == 1);
      end
      chk("busy_a", busy_a, m_active);
      chk("we_a", we_a, e_we);
      chk("re_a", re_a, e_re);
      if (e_we || e_re) chk("addr_a", addr_a, a);
      if (e_we) chk("wdata_a", wdata_a, pat(a, ph >= 2));
      chk("data_gen_a", gen_a, m_gen);
      chk("done_a", done_a, m_done);
      chk("pass_a", pass_a, m_done && m_cnt == 0);
      chk("err_a", err_a, sat(m_cnt, EWA));
      chk("fev_a", fev_a, m_fev);
      chk("fea_a", fea_a, m_fea);
      chk("busy_b", busy_b, m_active);
      chk("we_b", we_b, e_we);
      chk("re_b", re_b, e_re);
      if (e_we) chk("wdata_b", wdata_b, pat(a, ph >= 2));
      chk("data_gen_b", gen_b, m_gen);
      chk("done_b", done_b, m_done);
      chk("pass_b", pass_b, m_done && m_cnt == 0);
      chk("err_b", err_b, sat(m_cnt, EWB));
      chk("fev_b", fev_b, m_fev);
      chk("fea_b", fea_b, m_fea);
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int c);
    c = c0;
    while (!done_a && c < 300) begin
      @(negedge clk);
      c++;
    end
  endtask

  int c, k, r;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy_a, 0);
    chk("rst_we", we_a, 0);
    chk("rst_re", re_a, 0);
    chk("rst_gen", gen_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_pass", pass_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_fev", fev_a, 0);
    chk("rst_addr", addr_a, 0);
    chk_en = 1;
    rst = 1'b0;

    // Clean run
    mode = 0;
    pulse_start();
    wait_done(0, c);
    chk("clean_lat", c, DONE_LAT);
    chk("clean_pass", pass_a, 1);
    chk("clean_err", err_a, 0);
    chk("clean_fev", fev_a, 0);

    // Stuck bit 0 at address 3
    mode = 1;
    pulse_start();
    repeat (2) @(negedge clk);
    chk("wdata_k2", wdata_a, 8'hA8);
    repeat (D + 2) @(negedge clk);
    chk("gen_rd3", gen_a, 8'hA9);
    chk("rdata_rd3", rdata_a, 8'hA8);
    wait_done(D + 4, c);
    chk("stuck_lat", c, DONE_LAT);
    chk("stuck_err", err_a, 1);
    chk("stuck_fea", fea_a, 3);
    chk("stuck_pass", pass_a, 0);

    // Always-zero memory: 32 mismatches, 4-bit counter saturates
    mode = 2;
    pulse_start();
    wait_done(0, c);
    chk("zero_err_a", err_a, 32);
    chk("zero_err_b", err_b, 15);
    chk("zero_fea", fea_a, 0);
    chk("zero_fev", fev_a, 1);
    chk("zero_pass", pass_b, 0);

    // Restart from failing DONE clears status on the start edge
    mode = 0;
    pulse_start();
    chk("restart_err", err_a, 0);
    chk("restart_fev", fev_a, 0);
    chk("restart_done", done_a, 0);
    chk("restart_busy", busy_a, 1);
    wait_done(0, c);
    chk("restart_pass", pass_a, 1);

    // Reset at the 5th RD0 cycle discards the in-flight compare
    mode = 2;
    pulse_start();
    repeat (D + 4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy_a, 0);
    chk("midrst_re", re_a, 0);
    chk("midrst_err", err_a, 0);
    mode = 0;
    pulse_start();
    wait_done(0, c);
    chk("after_rst_lat", c, DONE_LAT);
    chk("after_rst_pass", pass_a, 1);

    // start during WR1 is ignored
    pulse_start();
    repeat (2 * D + 3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2 * D + 4, c);
    chk("wr1_start_lat", c, DONE_LAT);

    // rst and start on the same edge: rst wins
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", busy_a, 0);
    chk("rst_start_done", done_a, 0);

    // Randomized runs with random xor faults, resets and ignored starts
    for (int it = 0; it < 24; it++) begin
      mode = 3;
      for (int i = 0; i < D; i++)
        xmask[i] = ($urandom % 4 == 0) ? DW'($urandom_range(1, 255)) : '0;
      repeat ($urandom_range(0, 4)) @(negedge clk);
      pulse_start();
      r = $urandom % 4;
      k = $urandom_range(0, 4 * D);
      if (r == 0) begin
        repeat (k) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end else if (r == 1) begin
        repeat (k) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(k + 1, c);
        chk("rnd_start_lat", c, DONE_LAT);
      end else begin
        wait_done(0, c);
        chk("rnd_lat", c, DONE_LAT);
      end
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
